// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencing control path.
// State encoding, default multiplier latency and issue-mode constants.
package mac_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_WAIT_M = 3'd2;
    localparam logic [2:0] ST_ACC    = 3'd3;
    localparam logic [2:0] ST_STREAM = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;
    localparam logic [2:0] ST_OUT    = 3'd6;
    localparam logic [2:0] ST_HOLD   = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        WAIT_M = ST_WAIT_M,
        ACC    = ST_ACC,
        STREAM = ST_STREAM,
        DRAIN  = ST_DRAIN,
        OUT    = ST_OUT,
        HOLD   = ST_HOLD
    } state_t;

    localparam int MUL_LAT_DEF = 2;

    localparam int SEQ  = 0;
    localparam int PIPE = 1;

endpackage

// File: rtl/mac_strobe_delay.sv
// Shift-register delay line for the issue strobe in pipelined mode.
// Taps give the product-capture and accumulate strobes; pending flags in-flight work.
module mac_strobe_delay #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic strobe,
    output logic tap_m,
    output logic tap_acc,
    output logic pending
);

    logic [LAT:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (flush) begin
            sr <= '0;
        end else begin
            sr <= {sr[LAT-1:0], strobe};
        end
    end

    assign tap_m   = sr[LAT-1];
    assign tap_acc = sr[LAT];
    // Anything still short of the accumulate tap means more load_acc to come.
    assign pending = |sr[LAT-1:0];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Control path for the MAC unit: element counter, operand address and
// register load strobes, in sequential or pipelined issue mode.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int N_MAX     = 16,
    parameter int CNT_W     = $clog2(N_MAX + 1),
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int PIPELINED = SEQ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             out_ack,
    output logic             load_a,
    output logic             load_b,
    output logic             clr_acc,
    output logic             load_m,
    output logic             load_acc,
    output logic             load_out,
    output logic [CNT_W-1:0] addr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [WC_W-1:0]  W_LAST  = WC_W'(MUL_LAT - 1);
    localparam logic [WC_W-1:0]  W_ONE   = WC_W'(1);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(N_MAX);

    state_t st_q, st_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] len_q, len_n;
    logic [WC_W-1:0]  wc_q, wc_n;

    logic la_q, clr_q, lm_q, lacc_q, lout_q, busy_q, done_q, err_q;
    logic la_n, clr_n, lm_n, lacc_n, lout_n, busy_n, done_n, err_n;

    logic kill;
    logic last;
    logic dl_m, dl_acc, dl_pend;

    assign kill = abort && (st_q != IDLE);
    assign last = (cnt_q == len_q - C_ONE);

    mac_strobe_delay #(
        .LAT (MUL_LAT)
    ) u_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (kill),
        .strobe  ((PIPELINED == PIPE) && la_q),
        .tap_m   (dl_m),
        .tap_acc (dl_acc),
        .pending (dl_pend)
    );

    always_comb begin
        st_n  = st_q;
        cnt_n = cnt_q;
        len_n = len_q;
        wc_n  = wc_q;
        err_n = 1'b0;
        if (kill) begin
            st_n = IDLE;
        end else begin
            unique case (st_q)
                IDLE: begin
                    if (go) begin
                        if (len == '0 || len > LEN_MAX) begin
                            err_n = 1'b1;
                        end else begin
                            len_n = len;
                            cnt_n = '0;
                            st_n  = (PIPELINED == PIPE) ? STREAM : FETCH;
                        end
                    end
                end
                FETCH: begin
                    st_n = WAIT_M;
                    wc_n = '0;
                end
                WAIT_M: begin
                    if (wc_q == W_LAST) st_n = ACC;
                    else                wc_n = wc_q + W_ONE;
                end
                ACC: begin
                    if (last) begin
                        st_n = OUT;
                    end else begin
                        cnt_n = cnt_q + C_ONE;
                        st_n  = FETCH;
                    end
                end
                STREAM: begin
                    if (last) st_n = DRAIN;
                    else      cnt_n = cnt_q + C_ONE;
                end
                DRAIN: begin
                    if (!dl_pend) st_n = OUT;
                end
                OUT: begin
                    st_n = HOLD;
                end
                HOLD: begin
                    if (out_ack) st_n = IDLE;
                end
            endcase
        end

        // Outputs are registered, so they are decoded from the next state.
        la_n   = (st_n == FETCH) || (st_n == STREAM);
        clr_n  = la_n && (cnt_n == '0);
        lm_n   = (st_n == WAIT_M) && (wc_n == W_LAST);
        lacc_n = (st_n == ACC);
        lout_n = (st_n == OUT);
        busy_n = (st_n != IDLE);
        done_n = (st_n == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            len_q  <= '0;
            wc_q   <= '0;
            la_q   <= 1'b0;
            clr_q  <= 1'b0;
            lm_q   <= 1'b0;
            lacc_q <= 1'b0;
            lout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_n;
            cnt_q  <= cnt_n;
            len_q  <= len_n;
            wc_q   <= wc_n;
            la_q   <= la_n;
            clr_q  <= clr_n;
            lm_q   <= lm_n;
            lacc_q <= lacc_n;
            lout_q <= lout_n;
            busy_q <= busy_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    assign load_a   = la_q;
    assign load_b   = la_q;
    assign clr_acc  = clr_q;
    assign load_m   = (PIPELINED == PIPE) ? dl_m : lm_q;
    assign load_acc = (PIPELINED == PIPE) ? dl_acc : lacc_q;
    assign load_out = lout_q;
    assign addr     = cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: one sequential and one pipelined instance,
// expected strobe timelines computed from element timing arithmetic.
module tb_mac_seq_ctrl;

    localparam int NM = 16;
    localparam int CW = 5;
    localparam int ML = 2;

    localparam int B_BUSY = 8;
    localparam int B_DONE = 7;
    localparam int B_ERR  = 6;
    localparam int B_LA   = 5;
    localparam int B_LB   = 4;
    localparam int B_CLR  = 3;
    localparam int B_LM   = 2;
    localparam int B_LACC = 1;
    localparam int B_LOUT = 0;

    typedef struct {
        int         inst;
        int         cyc;
        logic [8:0] vec;
        int         addr;
    } ev_t;

    ev_t sb[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic          go_s = 0, abort_s = 0, ack_s = 0;
    logic [CW-1:0] len_s = '0;
    logic          la_s, lb_s, clr_s, lm_s, lacc_s, lout_s, busy_s, done_s, err_s;
    logic [CW-1:0] addr_s;

    logic          go_p = 0, abort_p = 0, ack_p = 0;
    logic [CW-1:0] len_p = '0;
    logic          la_p, lb_p, clr_p, lm_p, lacc_p, lout_p, busy_p, done_p, err_p;
    logic [CW-1:0] addr_p;

    logic [8:0] vec_s, vec_p;
    assign vec_s = {busy_s, done_s, err_s, la_s, lb_s, clr_s, lm_s, lacc_s, lout_s};
    assign vec_p = {busy_p, done_p, err_p, la_p, lb_p, clr_p, lm_p, lacc_p, lout_p};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_seq_ctrl #(.N_MAX(NM), .MUL_LAT(ML), .PIPELINED(0)) u_seq (
        .clk(clk), .rst_n(rst_n), .go(go_s), .len(len_s),
        .abort(abort_s), .out_ack(ack_s),
        .load_a(la_s), .load_b(lb_s), .clr_acc(clr_s), .load_m(lm_s),
        .load_acc(lacc_s), .load_out(lout_s), .addr(addr_s),
        .busy(busy_s), .done(done_s), .err(err_s)
    );

    mac_seq_ctrl #(.N_MAX(NM), .MUL_LAT(ML), .PIPELINED(1)) u_pipe (
        .clk(clk), .rst_n(rst_n), .go(go_p), .len(len_p),
        .abort(abort_p), .out_ack(ack_p),
        .load_a(la_p), .load_b(lb_p), .clr_acc(clr_p), .load_m(lm_p),
        .load_acc(lacc_p), .load_out(lout_p), .addr(addr_p),
        .busy(busy_p), .done(done_p), .err(err_p)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic [8:0] vec, input logic [CW-1:0] ad);
        ev_t e;
        if (vec != '0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb inst%0d cyc %0d: unexpected vec=%b, want nothing",
                         k, cyc, vec);
            end else begin
                e = sb.pop_front();
                if (e.inst != k || e.cyc != cyc || e.vec != vec ||
                    (vec[B_LA] && int'(ad) != e.addr)) begin
                    bad++;
                    $display("FAIL sb inst%0d cyc %0d: got vec=%b addr=%0d, want inst%0d cyc %0d vec=%b addr=%0d",
                             k, cyc, vec, ad, e.inst, e.cyc, e.vec, e.addr);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL sb missed inst%0d cyc %0d vec=%b",
                         sb[0].inst, sb[0].cyc, sb[0].vec);
                void'(sb.pop_front());
            end
            mon(0, vec_s, addr_s);
            mon(1, vec_p, addr_p);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic g, input logic [CW-1:0] l,
                         input logic ab, input logic ac);
        if (k == 0) begin
            go_s = g; len_s = l; abort_s = ab; ack_s = ac;
        end else begin
            go_p = g; len_p = l; abort_p = ab; ack_p = ac;
        end
    endtask

    function automatic int full_end(input int k, input int L, input int ackd);
        int last_acc;
        last_acc = (k == 0) ? L * (ML + 2) : L + ML + 1;
        return last_acc + 2 + ackd;
    endfunction

    // Expected activity relative to the go cycle t0, pushed as events.
    task automatic plan(input int k, input int t0, input int L, input int ackd,
                        input int abr, output int endr);
        logic [8:0] a [0:199];
        int ad [0:199];
        int f, o;
        ev_t e;
        for (int r = 0; r < 200; r++) begin
            a[r] = '0;
            ad[r] = 0;
        end
        if (L < 1 || L > NM) begin
            a[1][B_ERR] = 1'b1;
            endr = 1;
        end else begin
            for (int i = 0; i < L; i++) begin
                f = (k == 0) ? 1 + i * (ML + 2) : 1 + i;
                a[f][B_LA] = 1'b1;
                a[f][B_LB] = 1'b1;
                ad[f] = i;
                a[f + ML][B_LM] = 1'b1;
                a[f + ML + 1][B_LACC] = 1'b1;
            end
            a[1][B_CLR] = 1'b1;
            o = full_end(k, L, ackd) - 1 - ackd;
            a[o][B_LOUT] = 1'b1;
            endr = full_end(k, L, ackd);
            for (int r = o + 1; r <= endr; r++) a[r][B_DONE] = 1'b1;
            for (int r = 1; r <= endr; r++) a[r][B_BUSY] = 1'b1;
            if (abr > 0) endr = abr;
        end
        for (int r = 1; r <= endr; r++) begin
            if (a[r] != '0) begin
                e.inst = k;
                e.cyc  = t0 + r;
                e.vec  = a[r];
                e.addr = ad[r];
                sb.push_back(e);
            end
        end
    endtask

    task automatic run_op(input int k, input int L, input int ackd, input int abr,
                          input bit hold_go, input bit ack_abort);
        int t0, endr;
        bit bad_len;
        logic g, ac;
        bad_len = (L < 1 || L > NM);
        t0 = cyc;
        plan(k, t0, L, ackd, abr, endr);
        drive(k, 1'b1, CW'(L), 1'b0, 1'b0);
        for (int r = 1; r <= endr; r++) begin
            step();
            g = bad_len ? 1'b0 : (hold_go ? 1'b1 : 1'($urandom % 2));
            ac = (abr > 0) ? (r == abr && ack_abort) : (r == endr && !bad_len);
            drive(k, g, CW'($urandom), (r == abr), ac);
        end
        step();
        drive(k, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic rand_ops(input int k, input int n);
        int L, ackd, abr;
        for (int j = 0; j < n; j++) begin
            if ($urandom % 8 == 0) L = ($urandom % 2 == 0) ? 0 : $urandom_range(NM + 1, 31);
            else                   L = $urandom_range(1, NM);
            ackd = $urandom_range(0, 3);
            abr = 0;
            if (L >= 1 && L <= NM && $urandom % 4 == 0)
                abr = $urandom_range(1, full_end(k, L, ackd));
            run_op(k, L, ackd, abr, 1'($urandom % 2), 1'($urandom % 2));
            for (int g = 0; g < int'($urandom % 3); g++) begin
                drive(k, 1'b0, '0, 1'($urandom % 2), 1'b0);
                step();
                drive(k, 1'b0, '0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        int t0, endr;
        step();
        chk("rst busy_s", busy_s, 0);
        chk("rst done_s", done_s, 0);
        chk("rst strobes_s", vec_s, 0);
        chk("rst addr_s", addr_s, 0);
        chk("rst strobes_p", vec_p, 0);
        chk("rst addr_p", addr_p, 0);
        rst_n = 1'b1;
        step();

        run_op(0, 3, 0, 0, 0, 0);
        run_op(0, 2, 4, 0, 1, 0);
        run_op(0, 5, 1, 0, 0, 0);
        run_op(0, 0, 0, 0, 0, 0);
        run_op(0, NM + 1, 0, 0, 0, 0);
        run_op(0, NM, 0, 0, 0, 0);
        run_op(0, 1, 2, 7, 0, 1);
        rand_ops(0, 8);

        run_op(1, 4, 0, 0, 0, 0);
        run_op(1, 4, 0, 6, 0, 0);
        run_op(1, 3, 1, 0, 0, 0);
        run_op(1, 1, 0, 0, 1, 0);
        run_op(1, NM, 2, 0, 0, 0);
        run_op(1, 2, 1, 8, 0, 1);
        rand_ops(1, 8);

        t0 = cyc;
        plan(1, t0, 8, 0, 0, endr);
        drive(1, 1'b1, CW'(8), 1'b0, 1'b0);
        step();
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("async rst busy_p", busy_p, 0);
        chk("async rst strobes_p", vec_p, 0);
        chk("async rst addr_p", addr_p, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post rst busy_p", busy_p, 0);
        chk("post rst addr_p", addr_p, 0);
        run_op(1, 5, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) step();
        chk("sb drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Parametrised control path for the MAC unit. It sequences a multiply-accumulate over a vector of configurable length and drives the element address and the load strobes for the operand, product, accumulator and output registers. It supports a multiplier with configurable latency and two modes: sequential (one element in flight) and pipelined (one element issued per cycle). It sits beside the MAC datapath and owns the element counter.

Parameters:
N_MAX, 16, maximum vector length
CNT_W, $clog2(N_MAX+1), width of len and addr
MUL_LAT, 2, cycles from load_a/load_b to a valid product (>=1)
PIPELINED, 0, 0 = sequential mode, 1 = pipelined issue

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
go  in  1  start request, sampled only in IDLE
len  in  CNT_W  vector length, latched when go is accepted
abort  in  1  synchronous cancel, highest priority after reset
out_ack  in  1  consumer accepts result while done=1
load_a  out  1  load operand A register
load_b  out  1  load operand B register
clr_acc  out  1  clear accumulator
load_m  out  1  capture product register
load_acc  out  1  accumulate product into accumulator
load_out  out  1  copy accumulator to output register
addr  out  CNT_W  element index for the operand fetch
busy  out  1  high in every state except IDLE
done  out  1  result valid, held until out_ack
err  out  1  one-cycle pulse on a rejected go

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: state goes to IDLE. All outputs and addr are 0. The counter and the delay line are cleared. Reset asserted mid-operation discards the operation silently.
- All outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, FETCH, WAIT_M, ACC, STREAM, DRAIN, OUT, HOLD.
- go accept: cycle 0 is IDLE with go=1.
  - If len==0 or len>N_MAX: err=1 in cycle 1, state stays IDLE.
  - Otherwise len is latched and busy=1 from cycle 1.
- Sequential mode (PIPELINED=0), for element i:
  - FETCH (1 cycle): load_a=load_b=1, addr=i. clr_acc=1 only for i=0.
  - WAIT_M (MUL_LAT cycles): load_m=1 in the last of these cycles.
  - ACC (1 cycle): load_acc=1. If i==len-1 go to OUT, else i++ and go to FETCH.
  - Per element: MUL_LAT+2 cycles. Last load_acc lands in cycle L*(MUL_LAT+2).
- Pipelined mode (PIPELINED=1):
  - STREAM, cycles 1..L: load_a=load_b=1, addr=0..L-1. clr_acc=1 in cycle 1.
  - load_m is the issue strobe delayed by MUL_LAT (cycles 1+MUL_LAT..L+MUL_LAT).
  - load_acc is delayed by MUL_LAT+1.
  - DRAIN runs until the delay line is empty. Last load_acc lands in cycle L+MUL_LAT+1.
- OUT: load_out=1 for one cycle immediately after the last load_acc.
- HOLD: done=1 from the cycle after OUT and held until out_ack=1. done drops the next cycle, state returns to IDLE.
  - go is ignored in OUT and HOLD. A new go is accepted no earlier than the first IDLE cycle.
- abort in any non-IDLE state:
  - Next cycle: IDLE, all strobes 0, delay line flushed, no load_out, no done.
  - abort in IDLE has no effect.
  - abort together with out_ack in HOLD: treated as abort (same result, done drops).
- Boundaries:
  - addr never exceeds len-1, and holds its last value outside FETCH/STREAM.
  - L=1 with PIPELINED=1 is valid (STREAM lasts one cycle).
  - L=N_MAX must not overflow the counter, since CNT_W covers N_MAX.
- Arithmetic: the counter is unsigned CNT_W wide. Compare against len-1 only when len>=1, which the accept check guarantees.

Decomposition:
- Shared package mac_pkg holds:
  - state encoding localparams
  - the default MUL_LAT
  - the mode constants SEQ=0 and PIPE=1
- One sub-module, mac_strobe_delay: a parametrised shift-register delay line (depth MUL_LAT+1, synchronous flush input). It generates load_m and load_acc from the issue strobe in pipelined mode.

Test Plan:
1. PIPELINED=0, MUL_LAT=2, len=3, go for 1 cycle -> load_a at cycles 1,5,9 with addr 0,1,2; load_m at 3,7,11; load_acc at 4,8,12; load_out at 13; done from 14 until out_ack.
2. PIPELINED=1, MUL_LAT=2, len=4 -> load_a at cycles 1-4; clr_acc at 1; load_m at 3-6; load_acc at 4-7; load_out at 8; done at 9.
3. go with len=0, then go with len=N_MAX+1 -> err pulse one cycle each, busy stays 0, no strobes.
4. abort in cycle 6 of scenario 2 -> all strobes 0 from cycle 7, no load_out, busy=0 from cycle 7, and a following go is accepted normally.
5. Hold done for 5 cycles with go=1 throughout, then out_ack -> go ignored while done=1, done falls the next cycle, new operation starts from the first IDLE cycle.
6. rst_n low asynchronously mid-STREAM -> outputs 0 immediately; after release, state is IDLE with addr=0.
